// File: rtl/sc_level_control_pkg.sv
// rtl/sc_level_control_pkg.sv - shared FSM encoding, transition codes and default parameters
package sc_level_control_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_CLEARED  = 2'd2,
      ST_GAMEOVER = 2'd3
   } scState_t;

   localparam logic [2:0] TR_NONE   = 3'b000;
   localparam logic [2:0] TR_LEVEL1 = 3'b001;
   localparam logic [2:0] TR_LEVEL2 = 3'b010;
   localparam logic [2:0] TR_LEVEL3 = 3'b011;
   localparam logic [2:0] TR_LEVEL4 = 3'b100;
   localparam logic [2:0] TR_WON    = 3'b101;

   localparam int DIV_L1_DEF     = 40;
   localparam int DIV_L2_DEF     = 30;
   localparam int DIV_L3_DEF     = 20;
   localparam int DIV_L4_DEF     = 10;
   localparam int LIVES_INIT_DEF = 3;

   // Largest of the four per-level periods; sizes the tick counter.
   function automatic int maxOf4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/sc_tick_divider.sv
// rtl/sc_tick_divider.sv - game-speed counter with registered one-cycle pulse
module sc_tick_divider #(
   parameter int CW = 6
) (
   input  logic          SC_STATEMACHINE_MAIN_CLOCK_50,
   input  logic          SC_STATEMACHINE_MAIN_RESET_InHigh,
   input  logic          load,
   input  logic          enable,
   input  logic          arm,
   input  logic [CW-1:0] period,
   output logic          pulse
);

   logic [CW-1:0] count;
   logic [CW-1:0] countNext;

   // Next count: cleared on load, wraps at period-1 while counting, otherwise frozen.
   always_comb begin
      countNext = count;
      if (load) begin
         countNext = '0;
      end else if (enable) begin
         if (count >= period - CW'(1)) countNext = '0;
         else                          countNext = count + CW'(1);
      end
   end

   // Counter and pulse registers; pulse marks the cycle in which the counter sits at period-1.
   always_ff @(posedge SC_STATEMACHINE_MAIN_CLOCK_50 or posedge SC_STATEMACHINE_MAIN_RESET_InHigh) begin
      if (SC_STATEMACHINE_MAIN_RESET_InHigh) begin
         count <= '0;
         pulse <= 1'b0;
      end else begin
         count <= countNext;
         pulse <= arm && (countNext == period - CW'(1));
      end
   end

endmodule

// File: rtl/sc_level_control.sv
// rtl/sc_level_control.sv - level, lives and nest bookkeeping FSM with per-level game tick
module sc_level_control
   import sc_level_control_pkg::*;
#(
   parameter int NESTS      = 5,
   parameter int LIVES_INIT = LIVES_INIT_DEF,
   parameter int DIV_L1     = DIV_L1_DEF,
   parameter int DIV_L2     = DIV_L2_DEF,
   parameter int DIV_L3     = DIV_L3_DEF,
   parameter int DIV_L4     = DIV_L4_DEF
) (
   input  logic             SC_STATEMACHINE_MAIN_CLOCK_50,
   input  logic             SC_STATEMACHINE_MAIN_RESET_InHigh,
   input  logic             load_InLow,
   input  logic [2:0]       transition_InBUS,
   input  logic             nestValid_InLow,
   input  logic [2:0]       nestIdx_InBUS,
   input  logic             death_InLow,
   output logic             nidosCompletos_OutLow,
   output logic             perdioVidas_OutLow,
   output logic [2:0]       level_OutBUS,
   output logic [1:0]       lives_OutBUS,
   output logic [NESTS-1:0] nestMask_OutBUS,
   output logic             tick_OutHigh
);

   localparam int MAX_DIV = maxOf4(DIV_L1, DIV_L2, DIV_L3, DIV_L4);
   localparam int CW      = $clog2(MAX_DIV + 1);
   localparam logic [NESTS-1:0] ONE_HOT = NESTS'(1);

   scState_t         state, stateNext;
   logic [2:0]       levelNext;
   logic [1:0]       livesNext;
   logic [NESTS-1:0] maskNext, maskSet;
   logic             divLoad;
   logic             nidosNext, perdioNext;
   logic [CW-1:0]    periodNext;

   // State and registered outputs.
   always_ff @(posedge SC_STATEMACHINE_MAIN_CLOCK_50 or posedge SC_STATEMACHINE_MAIN_RESET_InHigh) begin
      if (SC_STATEMACHINE_MAIN_RESET_InHigh) begin
         state                 <= ST_IDLE;
         level_OutBUS          <= 3'd0;
         lives_OutBUS          <= 2'(LIVES_INIT);
         nestMask_OutBUS       <= '0;
         nidosCompletos_OutLow <= 1'b1;
         perdioVidas_OutLow    <= 1'b1;
      end else begin
         state                 <= stateNext;
         level_OutBUS          <= levelNext;
         lives_OutBUS          <= livesNext;
         nestMask_OutBUS       <= maskNext;
         nidosCompletos_OutLow <= nidosNext;
         perdioVidas_OutLow    <= perdioNext;
      end
   end

   // Next state: load beats level transitions, which beat in-play nest/death strobes.
   always_comb begin
      stateNext = state;
      levelNext = level_OutBUS;
      livesNext = lives_OutBUS;
      maskNext  = nestMask_OutBUS;
      divLoad   = 1'b0;
      maskSet   = nestMask_OutBUS | (ONE_HOT << nestIdx_InBUS);
      if (!load_InLow) begin
         stateNext = ST_IDLE;
         levelNext = 3'd0;
         livesNext = 2'(LIVES_INIT);
         maskNext  = '0;
         divLoad   = 1'b1;
      end else if (transition_InBUS >= TR_LEVEL1 && transition_InBUS <= TR_LEVEL4
                   && state != ST_GAMEOVER) begin
         stateNext = ST_RUN;
         levelNext = transition_InBUS;
         maskNext  = '0;
         divLoad   = 1'b1;
      end else if (transition_InBUS == TR_WON && state != ST_GAMEOVER) begin
         stateNext = ST_IDLE;
         levelNext = 3'd0;
      end else if (state == ST_RUN) begin
         if (!nestValid_InLow && int'(nestIdx_InBUS) < NESTS) begin
            maskNext = maskSet;
         end
         if (!nestValid_InLow && int'(nestIdx_InBUS) < NESTS && (&maskSet)) begin
            // Completing the level swallows a simultaneous death.
            stateNext = ST_CLEARED;
         end else if (!death_InLow) begin
            if (lives_OutBUS <= 2'd1) begin
               livesNext = 2'd0;
               stateNext = ST_GAMEOVER;
            end else begin
               livesNext = lives_OutBUS - 2'd1;
            end
         end
      end
   end

   // Status flags and tick period follow the state/level being entered, so they register in step.
   always_comb begin
      nidosNext  = (stateNext != ST_CLEARED);
      perdioNext = (stateNext != ST_GAMEOVER);
      case (levelNext)
         3'd2:    periodNext = CW'(DIV_L2);
         3'd3:    periodNext = CW'(DIV_L3);
         3'd4:    periodNext = CW'(DIV_L4);
         default: periodNext = CW'(DIV_L1);
      endcase
   end

   sc_tick_divider #(
      .CW(CW)
   ) uTickDivider (
      .SC_STATEMACHINE_MAIN_CLOCK_50     (SC_STATEMACHINE_MAIN_CLOCK_50),
      .SC_STATEMACHINE_MAIN_RESET_InHigh (SC_STATEMACHINE_MAIN_RESET_InHigh),
      .load                              (divLoad),
      .enable                            (state == ST_RUN),
      .arm                               (stateNext == ST_RUN),
      .period                            (periodNext),
      .pulse                             (tick_OutHigh)
   );

endmodule

// File: tb/tb_sc_level_control.sv
// tb/tb_sc_level_control.sv - directed self-checking bench for sc_level_control
module tb_sc_level_control;

   logic       clk;
   logic       rst;
   logic       loadN;
   logic [2:0] transition;
   logic       nestValidN;
   logic [2:0] nestIdx;
   logic       deathN;
   logic       nidosN;
   logic       perdioN;
   logic [2:0] level;
   logic [1:0] lives;
   logic [4:0] mask;
   logic       tick;

   int nChecks = 0;
   int nFail   = 0;

   sc_level_control #(
      .NESTS(5), .LIVES_INIT(3), .DIV_L1(4), .DIV_L2(3), .DIV_L3(2), .DIV_L4(1)
   ) dut (
      .SC_STATEMACHINE_MAIN_CLOCK_50     (clk),
      .SC_STATEMACHINE_MAIN_RESET_InHigh (rst),
      .load_InLow                        (loadN),
      .transition_InBUS                  (transition),
      .nestValid_InLow                   (nestValidN),
      .nestIdx_InBUS                     (nestIdx),
      .death_InLow                       (deathN),
      .nidosCompletos_OutLow             (nidosN),
      .perdioVidas_OutLow                (perdioN),
      .level_OutBUS                      (level),
      .lives_OutBUS                      (lives),
      .nestMask_OutBUS                   (mask),
      .tick_OutHigh                      (tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doTransition(input logic [2:0] code);
      transition = code;
      step();
      transition = 3'b000;
   endtask

   task automatic test_reset();
      rst = 1'b1; loadN = 1'b1; transition = 3'b000;
      nestValidN = 1'b1; nestIdx = 3'd0; deathN = 1'b1;
      #1;
      nChecks++; if (level !== 3'd0) begin nFail++; $display("FAIL reset_level got %0d exp 0", level); end
      nChecks++; if (lives !== 2'd3) begin nFail++; $display("FAIL reset_lives got %0d exp 3", lives); end
      nChecks++; if (mask !== 5'b00000) begin nFail++; $display("FAIL reset_mask got %b exp 00000", mask); end
      nChecks++; if (nidosN !== 1'b1 || perdioN !== 1'b1 || tick !== 1'b0) begin
         nFail++; $display("FAIL reset_flags got nidos=%b perdio=%b tick=%b exp 1 1 0", nidosN, perdioN, tick); end
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_start_tick();
      loadN = 1'b0;
      step();
      loadN = 1'b1;
      nChecks++; if (level !== 3'd0 || lives !== 2'd3) begin
         nFail++; $display("FAIL load_state got level=%0d lives=%0d exp 0 3", level, lives); end
      doTransition(3'b001);
      nChecks++; if (level !== 3'd1) begin nFail++; $display("FAIL start_level got %0d exp 1", level); end
      nChecks++; if (lives !== 2'd3 || mask !== 5'b00000) begin
         nFail++; $display("FAIL start_lives_mask got lives=%0d mask=%b exp 3 00000", lives, mask); end
      for (int k = 0; k < 12; k++) begin
         nChecks++;
         if (tick !== ((k % 4) == 3)) begin
            nFail++; $display("FAIL tick_div4 cycle %0d got %b exp %b", k, tick, (k % 4) == 3);
         end
         step();
      end
   endtask

   task automatic test_nests();
      logic [2:0] seq [6];
      logic [4:0] expMask [6];
      seq     = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
      expMask = '{5'b00001, 5'b00011, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
      for (int i = 0; i < 6; i++) begin
         nestValidN = 1'b0; nestIdx = seq[i];
         step();
         nestValidN = 1'b1;
         nChecks++; if (mask !== expMask[i]) begin
            nFail++; $display("FAIL nest_mask strobe %0d got %b exp %b", i, mask, expMask[i]); end
         nChecks++; if (nidosN !== (i != 5)) begin
            nFail++; $display("FAIL nest_nidos strobe %0d got %b exp %b", i, nidosN, i != 5); end
      end
      deathN = 1'b0;
      step();
      deathN = 1'b1;
      nChecks++; if (lives !== 2'd3) begin nFail++; $display("FAIL cleared_death_ignored got %0d exp 3", lives); end
      step(); step();
      nChecks++; if (nidosN !== 1'b0 || tick !== 1'b0) begin
         nFail++; $display("FAIL cleared_hold got nidos=%b tick=%b exp 0 0", nidosN, tick); end
      doTransition(3'b010);
      nChecks++; if (level !== 3'd2 || mask !== 5'b00000 || nidosN !== 1'b1) begin
         nFail++; $display("FAIL enter_level2 got level=%0d mask=%b nidos=%b exp 2 00000 1", level, mask, nidosN); end
   endtask

   task automatic test_deaths();
      for (int i = 0; i < 3; i++) begin
         deathN = 1'b0;
         step();
         deathN = 1'b1;
         nChecks++; if (lives !== 2'(2 - i)) begin
            nFail++; $display("FAIL death_lives %0d got %0d exp %0d", i, lives, 2 - i); end
         nChecks++; if (perdioN !== (i != 2)) begin
            nFail++; $display("FAIL death_perdio %0d got %b exp %b", i, perdioN, i != 2); end
      end
      deathN = 1'b0;
      nestValidN = 1'b0; nestIdx = 3'd0;
      step();
      deathN = 1'b1; nestValidN = 1'b1;
      nChecks++; if (mask !== 5'b00000 || lives !== 2'd0) begin
         nFail++; $display("FAIL gameover_strobes got mask=%b lives=%0d exp 00000 0", mask, lives); end
      doTransition(3'b011);
      nChecks++; if (level !== 3'd2 || perdioN !== 1'b0) begin
         nFail++; $display("FAIL gameover_hold got level=%0d perdio=%b exp 2 0", level, perdioN); end
      loadN = 1'b0;
      step();
      loadN = 1'b1;
      nChecks++; if (perdioN !== 1'b1 || nidosN !== 1'b1 || lives !== 2'd3 || level !== 3'd0) begin
         nFail++; $display("FAIL reload got perdio=%b nidos=%b lives=%0d level=%0d exp 1 1 3 0",
                           perdioN, nidosN, lives, level); end
   endtask

   task automatic test_complete_and_death();
      doTransition(3'b001);
      for (int i = 0; i < 4; i++) begin
         nestValidN = 1'b0; nestIdx = 3'(i);
         step();
      end
      nestIdx = 3'd6;
      step();
      nChecks++; if (mask !== 5'b01111) begin nFail++; $display("FAIL idx6_ignored got %b exp 01111", mask); end
      nestIdx = 3'd5;
      step();
      nChecks++; if (mask !== 5'b01111 || nidosN !== 1'b1) begin
         nFail++; $display("FAIL idx5_ignored got mask=%b nidos=%b exp 01111 1", mask, nidosN); end
      nestIdx = 3'd4; deathN = 1'b0;
      step();
      nestValidN = 1'b1; deathN = 1'b1;
      nChecks++; if (nidosN !== 1'b0 || lives !== 2'd3 || mask !== 5'b11111) begin
         nFail++; $display("FAIL complete_vs_death got nidos=%b lives=%0d mask=%b exp 0 3 11111", nidosN, lives, mask); end
   endtask

   task automatic test_level4_won();
      doTransition(3'b100);
      nChecks++; if (level !== 3'd4 || mask !== 5'b00000 || nidosN !== 1'b1) begin
         nFail++; $display("FAIL enter_level4 got level=%0d mask=%b nidos=%b exp 4 00000 1", level, mask, nidosN); end
      for (int k = 0; k < 3; k++) begin
         nChecks++; if (tick !== 1'b1) begin nFail++; $display("FAIL tick_div1 cycle %0d got %b exp 1", k, tick); end
         step();
      end
      doTransition(3'b101);
      nChecks++; if (level !== 3'd0 || nidosN !== 1'b1) begin
         nFail++; $display("FAIL won_idle got level=%0d nidos=%b exp 0 1", level, nidosN); end
      for (int k = 0; k < 3; k++) begin
         nChecks++; if (tick !== 1'b0) begin nFail++; $display("FAIL tick_stopped cycle %0d got %b exp 0", k, tick); end
         step();
      end
   endtask

   task automatic test_reset_midrun();
      doTransition(3'b010);
      nestValidN = 1'b0; nestIdx = 3'd0;
      step();
      nestValidN = 1'b1; deathN = 1'b0;
      step();
      deathN = 1'b1;
      nChecks++; if (lives !== 2'd2 || mask !== 5'b00001) begin
         nFail++; $display("FAIL pre_reset got lives=%0d mask=%b exp 2 00001", lives, mask); end
      #3;
      rst = 1'b1;
      #1;
      nChecks++; if (level !== 3'd0 || lives !== 2'd3 || mask !== 5'b00000) begin
         nFail++; $display("FAIL async_reset_regs got level=%0d lives=%0d mask=%b exp 0 3 00000", level, lives, mask); end
      nChecks++; if (nidosN !== 1'b1 || perdioN !== 1'b1 || tick !== 1'b0) begin
         nFail++; $display("FAIL async_reset_flags got nidos=%b perdio=%b tick=%b exp 1 1 0", nidosN, perdioN, tick); end
      step();
      rst = 1'b0;
      step(); step();
      nChecks++; if (level !== 3'd0 || tick !== 1'b0) begin
         nFail++; $display("FAIL post_reset_idle got level=%0d tick=%b exp 0 0", level, tick); end
      doTransition(3'b001);
      nChecks++; if (level !== 3'd1) begin nFail++; $display("FAIL post_reset_run got %0d exp 1", level); end
   endtask

   initial begin
      test_reset();
      test_start_tick();
      test_nests();
      test_deaths();
      test_complete_and_death();
      test_level4_won();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
